interp_acc_s32: RTL and testbench

INTERP_ACC_S32 -- requirements
Module: interp_acc_s32

---
 rtl/interp_acc_s32.sv | 168 ++++++++++++++++
 tb/tb_interp_acc_s32.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/interp_acc_s32.sv
// ---------------------------------------------------------------------------
// interp_acc_s32
//
// Purpose:
//   Accumulates NTERM weighted LUT terms (signed 32-bit value times unsigned
//   weight) into one undivided interpolation sum. The sum is handed to a
//   downstream round-divide stage over a valid/ready handshake. The block
//   stalls input while a result is pending.
//
// Configuration:
//   INTERP_ACC_SAT_EN - when defined, the final sum is clamped to the signed
//                       32-bit range and out_ovf flags the clamp. When it is
//                       undefined (the default build), the low 32 bits are
//                       passed through and out_ovf is always 0.
//
// Parameters:
//   NTERM - terms per output sample (1..16)
//   WW    - unsigned weight width
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   in_valid  - a term is presented
//   in_ready  - term accepted this cycle (high in ACC, low in HOLD)
//   in_val    - signed 32-bit LUT value
//   in_wt     - unsigned weight
//   in_flush  - discard the partial sample (ignored in HOLD)
//   out_valid - out_sum/out_ovf are valid
//   out_ready - downstream accepts the result
//   out_sum   - signed weighted sum, undivided
//   out_ovf   - sum exceeded the signed 32-bit range (saturating build only)
// ---------------------------------------------------------------------------
module interp_acc_s32 #(
  parameter int NTERM = 4,
  parameter int WW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_val,
  input  logic [WW-1:0] in_wt,
  input  logic          in_flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_sum,
  output logic          out_ovf
);

  // The product width holds any signed 32-bit value times any WW-bit weight.
  // The accumulator adds enough headroom bits for NTERM products plus a spare
  // bit, so it can never wrap.
  localparam int PW = 33 + WW;
  localparam int AW = PW + $clog2(NTERM) + 1;
  localparam int CW = (NTERM > 1) ? $clog2(NTERM) : 1;
  localparam logic [CW-1:0] LAST = CW'(NTERM - 1);

  typedef enum logic {
    ACC,
    HOLD
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] total;
  logic [31:0]          res_sum;
  logic                 res_ovf;
  logic                 out_load;

  // The weight is zero-extended by one bit so that the signed multiply treats
  // it as non-negative. The operands widen to PW before the multiply.
  assign prod     = $signed(in_val) * $signed({1'b0, in_wt});
  assign prod_ext = {{(AW - PW){prod[PW-1]}}, prod};

  // The first term of a sample loads the accumulator instead of adding, so
  // stale contents from a previous sample never leak into the next one.
  assign total = (cnt == '0) ? prod_ext : (acc + prod_ext);

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);

`ifdef INTERP_ACC_SAT_EN
  localparam logic signed [AW-1:0] SMAX = {{(AW - 31){1'b0}}, {31{1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW - 31){1'b1}}, {31{1'b0}}};

  // Clamp the full-width sum into the signed 32-bit range and flag the clamp.
  always_comb begin
    res_sum = total[31:0];
    res_ovf = 1'b0;
    if (total > SMAX) begin
      res_sum = 32'h7FFF_FFFF;
      res_ovf = 1'b1;
    end else if (total < SMIN) begin
      res_sum = 32'h8000_0000;
      res_ovf = 1'b1;
    end
  end
`else
  // Two's-complement wrap: only the low 32 bits leave the block.
  always_comb begin
    res_sum = total[31:0];
    res_ovf = 1'b0;
  end
`endif

  // Next-state logic. A flush in ACC wins over a simultaneous term, so the
  // handshake completes but the term is dropped. In HOLD, both new terms and
  // flushes are ignored until the pending result is taken.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    acc_next   = acc;
    out_load   = 1'b0;
    case (state)
      ACC: begin
        if (in_flush) begin
          cnt_next = '0;
          acc_next = '0;
        end else if (in_valid) begin
          if (cnt == LAST) begin
            out_load   = 1'b1;
            cnt_next   = '0;
            state_next = HOLD;
          end else begin
            acc_next = total;
            cnt_next = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = ACC;
        end
      end
      default: begin
        state_next = ACC;
        cnt_next   = '0;
      end
    endcase
  end

  // State and result registers. The result only changes on the cycle that
  // completes a sample, so it stays stable while downstream back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACC;
      cnt     <= '0;
      acc     <= '0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      acc   <= acc_next;
      if (out_load) begin
        out_sum <= res_sum;
        out_ovf <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_interp_acc_s32.sv
// ---------------------------------------------------------------------------
// tb_interp_acc_s32
//
// Self-checking bench for interp_acc_s32 at default parameters (NTERM=4,
// WW=5). Expected values come from a hand-filled vector table and from a
// plain-arithmetic reference model (64-bit sum, then clamp or wrap). The
// bench honours INTERP_ACC_SAT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_interp_acc_s32;

`ifdef INTERP_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_val = '0;
  logic [4:0]  in_wt = '0;
  logic        in_flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_ovf;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          v[4];
    int          w[4];
    logic [31:0] es;
    logic        eo;
  } vec_t;

  vec_t tbl[$];

  interp_acc_s32 #(.NTERM(4), .WW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .in_wt     (in_wt),
    .in_flush  (in_flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h (%0d), expected 0x%08h (%0d)", name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  // Drive one cycle of input, let the clock edge happen, and return 1 time
  // unit after that edge with the term strobes released.
  task automatic applyStimulus(input int v, input int w, input logic vld, input logic fl);
    in_valid = vld;
    in_val   = v;
    in_wt    = w[4:0];
    in_flush = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  // Reference model: exact 64-bit sum, then saturate or wrap.
  function automatic void refOut(input longint s, output logic [31:0] es, output logic eo);
    if (SAT && s > 64'sd2147483647) begin
      es = 32'h7FFF_FFFF;
      eo = 1'b1;
    end else if (SAT && s < -64'sd2147483648) begin
      es = 32'h8000_0000;
      eo = 1'b1;
    end else begin
      es = s[31:0];
      eo = 1'b0;
    end
  endfunction

  task automatic addVec(input int v0, input int v1, input int v2, input int v3,
                        input int w0, input int w1, input int w2, input int w3,
                        input logic [31:0] es, input logic eo);
    vec_t t;
    t.v[0] = v0; t.v[1] = v1; t.v[2] = v2; t.v[3] = v3;
    t.w[0] = w0; t.w[1] = w1; t.w[2] = w2; t.w[3] = w3;
    t.es = es;
    t.eo = eo;
    tbl.push_back(t);
  endtask

  // Feed four terms back to back and check the result that appears one
  // cycle after the last handshake.
  task automatic runSample(input string name, input int v[4], input int w[4],
                           input logic [31:0] es, input logic eo);
    for (int i = 0; i < 4; i++) begin
      checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd1);
      applyStimulus(v[i], w[i], 1'b1, 1'b0);
      if (i < 3) checkOutput({name, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, "_sum"}, out_sum, es);
    checkOutput({name, "_ovf"}, 32'(out_ovf), 32'(eo));
  endtask

  initial begin
    int          v[4];
    int          w[4];
    logic [31:0] es;
    logic        eo;
    longint      s;
    int          k;

    // ---------------- vector table ----------------
    addVec(100, 200, -50, 10, 4, 4, 4, 4, 32'd1040, 1'b0);
    addVec(int'(32'h7FFF_FFFF), int'(32'h7FFF_FFFF), int'(32'h7FFF_FFFF), int'(32'h7FFF_FFFF),
           16, 16, 16, 16, SAT ? 32'h7FFF_FFFF : 32'hFFFF_FFC0, SAT);
    addVec(5, 6, 7, 8, 0, 0, 16, 0, 32'd112, 1'b0);
    addVec(int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000), int'(32'h8000_0000),
           16, 16, 16, 16, SAT ? 32'h8000_0000 : 32'h0000_0000, SAT);
    addVec(1, -1, 2, 3, 31, 31, 31, 31, 32'd155, 1'b0);
    addVec(-1000, 0, -3, 25, 7, 31, 1, 2, 32'hFFFF_E4D7, 1'b0);
    addVec(int'(32'h7FFF_FFFF), 0, 0, 0, 1, 0, 5, 16, 32'h7FFF_FFFF, 1'b0);
    addVec(32'h4000_0000, 0, 0, 0, 2, 0, 0, 0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, SAT);
    addVec(-32'sh4000_0000, 0, 0, 0, 2, 0, 0, 0, 32'h8000_0000, 1'b0);

    // ---------------- reset ----------------
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_sum", out_sum, 32'd0);
    checkOutput("reset_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- table-driven samples ----------------
    out_ready = 1'b1;
    foreach (tbl[n]) begin
      runSample($sformatf("tbl%0d", n), tbl[n].v, tbl[n].w, tbl[n].es, tbl[n].eo);
      applyStimulus(0, 0, 1'b0, 1'b0);
      checkOutput($sformatf("tbl%0d_release_valid", n), 32'(out_valid), 32'd0);
      checkOutput($sformatf("tbl%0d_release_ready", n), 32'(in_ready), 32'd1);
    end

    // ---------------- back-pressure: result held, input stalled ----------------
    out_ready = 1'b0;
    v = '{3, 3, 3, 3};
    w = '{2, 2, 2, 2};
    runSample("hold", v, w, 32'd24, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5, 5, 1'b1, 1'b1);
      checkOutput("hold_sum_stable", out_sum, 32'd24);
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    applyStimulus(0, 0, 1'b0, 1'b0);
    checkOutput("hold_release_ready", 32'(in_ready), 32'd1);
    checkOutput("hold_release_valid", 32'(out_valid), 32'd0);

    // ---------------- flush with a dropped term ----------------
    applyStimulus(1000, 16, 1'b1, 1'b0);
    applyStimulus(1000, 16, 1'b1, 1'b0);
    checkOutput("flush_ready", 32'(in_ready), 32'd1);
    applyStimulus(999, 16, 1'b1, 1'b1);
    checkOutput("flush_no_valid", 32'(out_valid), 32'd0);
    v = '{1, 2, 3, 4};
    w = '{1, 1, 1, 1};
    runSample("flush", v, w, 32'd10, 1'b0);
    applyStimulus(0, 0, 1'b0, 1'b0);

    // ---------------- asynchronous reset mid-sample ----------------
    for (int i = 0; i < 3; i++) applyStimulus(77, 3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_sum", out_sum, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 0, 1'b0, 1'b0);
    checkOutput("midrst_after_valid", 32'(out_valid), 32'd0);
    v = '{-8, -8, -8, -8};
    w = '{2, 2, 2, 2};
    runSample("midrst", v, w, 32'hFFFF_FFC0, 1'b0);
    applyStimulus(0, 0, 1'b0, 1'b0);

    // ---------------- randomized samples against the reference model ----------------
    out_ready = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) applyStimulus(int'($urandom), int'($urandom_range(0, 31)), 1'b1, 1'b0);
        applyStimulus(int'($urandom), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1);
      end
      s = 0;
      for (int i = 0; i < 4; i++) begin
        v[i] = int'($urandom);
        w[i] = (n < 8) ? 16 : int'($urandom_range(0, 31));
        if ($urandom_range(0, 2) == 0) applyStimulus(0, 0, 1'b0, 1'b0);
        s += longint'(v[i]) * longint'(w[i]);
        applyStimulus(v[i], w[i], 1'b1, 1'b0);
      end
      refOut(s, es, eo);
      checkOutput($sformatf("rnd%0d_valid", n), 32'(out_valid), 32'd1);
      checkOutput($sformatf("rnd%0d_sum", n), out_sum, es);
      checkOutput($sformatf("rnd%0d_ovf", n), 32'(out_ovf), 32'(eo));
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        applyStimulus(int'($urandom), int'($urandom_range(0, 31)), 1'b1, 1'($urandom_range(0, 1)));
        checkOutput($sformatf("rnd%0d_stable", n), out_sum, es);
      end
      out_ready = 1'b1;
      applyStimulus(0, 0, 1'b0, 1'b0);
      out_ready = 1'b0;
      checkOutput($sformatf("rnd%0d_release", n), 32'(in_ready), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
